// File: rtl/ddr4_rd_unpack_if.sv
// ddr4_rd_unpack_if
//   Bundles the signals between the DDR4 read controller / MIG side and the
//   read-return unpacker. The unpacker connects through the slave modport.
//   Its environment (the controller and the downstream consumer) connects
//   through the master modport.
//   Signals:
//     app_rd_data_valid / app_rd_data : MIG read beat (no back-pressure)
//     rfifo_wcount                    : FIFO fill level reported to controller
//     ddr4_read_valid                 : controller may issue another burst
//     m_valid / m_ready / m_data / m_last : symbol stream to the deinterleaver
//     clr_err / ovf_err               : sticky overflow flag and its clear
interface ddr4_rd_unpack_if #(
  parameter int DATA_WIDTH = 512,
  parameter int OUT_WIDTH  = 64
);
  logic                  app_rd_data_valid;
  logic [DATA_WIDTH-1:0] app_rd_data;
  logic [8:0]            rfifo_wcount;
  logic                  ddr4_read_valid;
  logic                  m_valid;
  logic                  m_ready;
  logic [OUT_WIDTH-1:0]  m_data;
  logic                  m_last;
  logic                  clr_err;
  logic                  ovf_err;

  modport slave (
    input  app_rd_data_valid, app_rd_data, m_ready, clr_err,
    output rfifo_wcount, ddr4_read_valid, m_valid, m_data, m_last, ovf_err
  );

  modport master (
    output app_rd_data_valid, app_rd_data, m_ready, clr_err,
    input  rfifo_wcount, ddr4_read_valid, m_valid, m_data, m_last, ovf_err
  );
endinterface

// File: rtl/ddr4_rd_unpack.sv
// ddr4_rd_unpack
//   Read-return stage behind the DDR4 deinterleave controller. Every MIG
//   read beat is written into a synchronous FIFO. The fill level and a
//   "room for another burst" flag are reported back to the controller.
//   Buffered words are split into OUT_WIDTH symbols, lane 0 (LSBs) first,
//   and sent on a valid/ready stream. m_last marks every FRAME_LEN-th symbol.
//   Ports:
//     ui_clk : user clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : ddr4_rd_unpack_if.slave (MIG beats, status, symbol stream)
module ddr4_rd_unpack #(
  parameter int DATA_WIDTH = 512,
  parameter int OUT_WIDTH  = 64,
  parameter int DEPTH      = 256,
  parameter int FRAME_LEN  = 64,
  parameter int RD_RESERVE = 16
) (
  input  logic            ui_clk,
  input  logic            rst_n,
  ddr4_rd_unpack_if.slave bus
);
  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int FW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CW    = 9;

  typedef enum logic [1:0] {EMPTY, LOAD, SEND} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic [DATA_WIDTH-1:0] word_reg;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         frame_cnt;
  logic                  read_valid_q, ovf_q;
  logic                  fifo_empty, fifo_full, hs, last_lane;
  logic                  push, pop, drop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign hs         = (state == SEND) && bus.m_ready;
  assign last_lane  = (idx == IW'(RATIO - 1));

  // Pop to start a new word when idle, or on the last lane's handshake.
  // Popping on the last lane keeps the stream free of gaps between words.
  assign pop  = !fifo_empty && ((state == EMPTY) || (hs && last_lane));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the beat.
  assign push = bus.app_rd_data_valid && (!fifo_full || pop);
  assign drop = bus.app_rd_data_valid && fifo_full && !pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  // NOTE: the storage array has no reset. The pointers and the count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge ui_clk) begin
    if (push) mem[wr_ptr] <= bus.app_rd_data;
  end

  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples the pre-edge values. This holds even when a push and
  // a pop hit the same full-FIFO entry: the pop reads the old word.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      read_valid_q <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nxt;
      read_valid_q <= (CW'(DEPTH) - count_nxt) >= CW'(RD_RESERVE);
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_err) ovf_q <= 1'b0;
    end
  end

  // Unpacker FSM: state register.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // NOTE: next-state logic assigns its default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (pop) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (hs && last_lane && !pop) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Unpack datapath: the popped word lands in word_reg when the pop happens.
  // LOAD then restarts the lane index.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
    end else begin
      if (pop) word_reg <= mem[rd_ptr];
      if (state == LOAD)   idx <= '0;
      else if (hs)         idx <= last_lane ? '0 : idx + IW'(1);
      if (hs) frame_cnt <= (frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : frame_cnt + FW'(1);
    end
  end

  assign bus.m_valid         = (state == SEND);
  assign bus.m_data          = word_reg[OUT_WIDTH*idx +: OUT_WIDTH];
  assign bus.m_last          = bus.m_valid && (frame_cnt == FW'(FRAME_LEN - 1));
  assign bus.rfifo_wcount    = count;
  assign bus.ddr4_read_valid = read_valid_q;
  assign bus.ovf_err         = ovf_q;
endmodule

// File: tb/tb_ddr4_rd_unpack.sv
// tb_ddr4_rd_unpack
//   Scoreboard bench for ddr4_rd_unpack. Each accepted beat pushes its eight
//   expected symbols into a queue. A negedge monitor pops and compares every
//   handshaken symbol and its m_last flag.
module tb_ddr4_rd_unpack;
  localparam int DW = 512;
  localparam int OW = 64;
  localparam int RATIO = DW / OW;
  localparam int DEPTH = 256;
  localparam int FRAME_LEN = 64;

  logic ui_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 ui_clk = ~ui_clk;

  ddr4_rd_unpack_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  ddr4_rd_unpack #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH),
    .FRAME_LEN(FRAME_LEN), .RD_RESERVE(16)
  ) dut (
    .ui_clk (ui_clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [OW-1:0] exp_q [$];
  int sym_cnt  = 0;
  int cyc      = 0;
  int first_hs = -1;
  int last_hs  = -1;
  int hs_n     = 0;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] mk_word(input int id);
    logic [DW-1:0] w;
    for (int k = 0; k < RATIO; k++) w[OW*k +: OW] = {id[31:0], 32'(k + 1)};
    return w;
  endfunction

  always @(posedge ui_clk) cyc++;

  // Monitor: the handshake completes at the following posedge.
  always @(negedge ui_clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_symbol", 64'(bus.m_valid), 64'(0));
      end else begin
        check("m_data", bus.m_data, exp_q.pop_front());
        check("m_last", 64'(bus.m_last), 64'((sym_cnt % FRAME_LEN) == FRAME_LEN - 1));
      end
      sym_cnt++;
      hs_n++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
  end

  // One cycle of stimulus: optionally present a beat, then advance to #1 after the edge.
  task automatic step(input logic v, input int id, input logic accept);
    bus.app_rd_data_valid = v;
    if (v) begin
      bus.app_rd_data = mk_word(id);
      if (accept)
        for (int k = 0; k < RATIO; k++) exp_q.push_back({id[31:0], 32'(k + 1)});
    end
    @(posedge ui_clk);
    #1;
    bus.app_rd_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    sym_cnt = 0; hs_n = 0; first_hs = -1; last_hs = -1;
    repeat (2) @(posedge ui_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bus.m_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge ui_clk);
      n++;
    end
    repeat (3) @(posedge ui_clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data = '0;
    bus.m_ready = 1'b0;
    bus.clr_err = 1'b0;

    // Reset values and single-word latency.
    do_reset();
    check("rst_wcount", 64'(bus.rfifo_wcount), 64'(0));
    check("rst_rdvalid", 64'(bus.ddr4_read_valid), 64'(1));
    check("rst_m_valid", 64'(bus.m_valid), 64'(0));
    check("rst_m_data", bus.m_data, 64'(0));
    check("rst_m_last", 64'(bus.m_last), 64'(0));
    check("rst_ovf", 64'(bus.ovf_err), 64'(0));
    bus.m_ready = 1'b1;
    step(1'b1, 0, 1'b1);                    // sampled at edge N
    check("lat_cnt_n", 64'(bus.rfifo_wcount), 64'(1));
    check("lat_valid_n", 64'(bus.m_valid), 64'(0));
    step(1'b0, 0, 1'b0);                    // edge N+1: pop
    check("lat_cnt_n1", 64'(bus.rfifo_wcount), 64'(0));
    check("lat_valid_n1", 64'(bus.m_valid), 64'(0));
    step(1'b0, 0, 1'b0);                    // edge N+2: lane 0 out
    check("lat_valid_n2", 64'(bus.m_valid), 64'(1));
    check("lat_data_n2", bus.m_data, 64'(1));
    drain(50);

    // 16 back-to-back beats: 128 contiguous symbols.
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 16 + i, 1'b1);
    drain(500);
    check("stream_hs_count", 64'(hs_n), 64'(128));
    check("stream_no_gap", 64'(last_hs - first_hs), 64'(127));

    // Fill with m_ready low, then overflow.
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 100 + i, 1'b1);
      if (i == 0)   check("fill_cnt0", 64'(bus.rfifo_wcount), 64'(1));
      if (i == 240) begin
        check("fill_cnt240", 64'(bus.rfifo_wcount), 64'(240));
        check("rdvalid_240", 64'(bus.ddr4_read_valid), 64'(1));
      end
      if (i == 241) begin
        check("fill_cnt241", 64'(bus.rfifo_wcount), 64'(241));
        check("rdvalid_241", 64'(bus.ddr4_read_valid), 64'(0));
      end
    end
    check("fill_cnt255", 64'(bus.rfifo_wcount), 64'(255));
    check("fill_ovf0", 64'(bus.ovf_err), 64'(0));
    check("stall_valid", 64'(bus.m_valid), 64'(1));
    check("stall_data", bus.m_data, {32'd100, 32'd1});
    check("stall_last", 64'(bus.m_last), 64'(0));
    step(1'b1, 356, 1'b1);
    check("full_cnt", 64'(bus.rfifo_wcount), 64'(256));
    check("full_ovf0", 64'(bus.ovf_err), 64'(0));
    step(1'b1, 357, 1'b0);                  // dropped beat
    check("drop_cnt", 64'(bus.rfifo_wcount), 64'(256));
    check("drop_ovf", 64'(bus.ovf_err), 64'(1));
    drain(3000);
    check("ovf_sticky", 64'(bus.ovf_err), 64'(1));
    bus.clr_err = 1'b1;
    step(1'b0, 0, 1'b0);
    bus.clr_err = 1'b0;
    check("ovf_cleared", 64'(bus.ovf_err), 64'(0));

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 257; i++) step(1'b1, 1000 + i, 1'b1);
    check("pp_full_cnt", 64'(bus.rfifo_wcount), 64'(256));
    bus.m_ready = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b0, 0, 1'b0);
    step(1'b1, 1257, 1'b1);                 // coincides with the last-lane pop
    check("pp_cnt", 64'(bus.rfifo_wcount), 64'(256));
    check("pp_ovf", 64'(bus.ovf_err), 64'(0));
    drain(3000);

    // Random back-pressure with a reset in the middle of a word.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      step(i < 3, 2000 + i, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wcount", 64'(bus.rfifo_wcount), 64'(0));
    check("mid_rst_rdvalid", 64'(bus.ddr4_read_valid), 64'(1));
    check("mid_rst_m_valid", 64'(bus.m_valid), 64'(0));
    check("mid_rst_m_data", bus.m_data, 64'(0));
    check("mid_rst_m_last", 64'(bus.m_last), 64'(0));
    check("mid_rst_ovf", 64'(bus.ovf_err), 64'(0));
    exp_q.delete();
    sym_cnt = 0;
    @(posedge ui_clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      step(i < 10, 3000 + i, 1'b1);
    end
    drain(500);
    check("post_rst_syms", 64'(sym_cnt), 64'(80));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
